fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the hardware-scheduled MIPS pipeline. Holds the PC, drives the instruction-memory address, and latches the fetched instruction into the ID stage. Consumes the `stall` and `flush` outputs of the hazard detection unit together with the ID-stage redirect selects and targets. Keeps stall/flush event counters for performance debug.

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage plus the IF/ID pipeline register for the
// hardware-scheduled MIPS pipeline. Holds the PC, presents it to the
// instruction memory, and latches the fetched word into ID. Honours the
// hazard unit's stall/flush and the ID-stage redirect selects, and keeps
// free-running stall/flush event counters for performance debug.
//
// Ports:
//   i_CLK, i_RST         clock, synchronous active-high reset
//   stall, flush         hazard unit controls (stall has priority)
//   jump_reg, jump_addr, branch
//                        redirect selects from ID (priority in that order)
//   jr_target            register operand for jr/jalr
//   jump_index           instr[25:0] of the ID instruction
//   branch_imm           instr[15:0] of the ID instruction
//   imem_addr, imem_data instruction memory (asynchronous read)
//   pc_IF                current PC
//   instr_ID, pc_plus4_ID, valid_ID
//                        IF/ID register contents (valid_ID=0 marks a bubble)
//   stall_count          cycles in which a stall was honoured
//   flush_count          redirects taken
module fetch_stage #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  jump_reg,
    input  logic                  jump_addr,
    input  logic                  branch,
    input  logic [DATA_WIDTH-1:0] jr_target,
    input  logic [25:0]           jump_index,
    input  logic [15:0]           branch_imm,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] pc_IF,
    output logic [DATA_WIDTH-1:0] instr_ID,
    output logic [DATA_WIDTH-1:0] pc_plus4_ID,
    output logic                  valid_ID,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
);

    logic [DATA_WIDTH-1:0] pc_seq;
    logic [DATA_WIDTH-1:0] branch_offset;
    logic [DATA_WIDTH-1:0] target;
    logic                  jr_low_unused;

    // The memory address comes straight from the PC register so there is
    // no combinational path from any input to imem_addr.
    assign imem_addr = pc_IF;

    // jr/jalr targets are silently word-aligned; the two low bits of the
    // register value are deliberately ignored.
    assign jr_low_unused = ^jr_target[1:0];

    // Redirect target. A flush with no select asserted simply continues
    // sequentially, but the IF/ID contents are still squashed.
    always_comb begin
        pc_seq        = pc_IF + 32'd4;
        branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};
        if (jump_reg) begin
            target = {jr_target[31:2], 2'b00};
        end else if (jump_addr) begin
            target = {pc_plus4_ID[31:28], jump_index, 2'b00};
        end else if (branch) begin
            target = pc_plus4_ID + branch_offset;
        end else begin
            target = pc_seq;
        end
    end

    // PC, IF/ID register and counters. Stall beats flush because the ID
    // instruction's operands are not valid yet; the redirect is taken on
    // the first unstalled cycle while ID still asserts it.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pc_IF       <= RESET_PC;
            instr_ID    <= '0;
            pc_plus4_ID <= '0;
            valid_ID    <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end else if (flush) begin
            pc_IF       <= target;
            instr_ID    <= '0;
            pc_plus4_ID <= '0;
            valid_ID    <= 1'b0;
            flush_count <= flush_count + 32'd1;
        end else begin
            pc_IF       <= pc_seq;
            instr_ID    <= imem_data;
            pc_plus4_ID <= pc_seq;
            valid_ID    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage. Each table row gives the
// inputs for one clock cycle and the register contents expected after that
// edge. The instruction memory returns address + 0x1000_0000 so every
// fetched word identifies the address it came from.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        jump_reg;
    logic        jump_addr;
    logic        branch;
    logic [31:0] jr_target;
    logic [25:0] jump_index;
    logic [15:0] branch_imm;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_IF;
    logic [31:0] instr_ID;
    logic [31:0] pc_plus4_ID;
    logic        valid_ID;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int tests;
    int failures;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        jr;
        logic        ja;
        logic        br;
        logic [31:0] jr_target;
        logic [25:0] jidx;
        logic [15:0] bimm;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_sc;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[$];

    fetch_stage dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .stall       (stall),
        .flush       (flush),
        .jump_reg    (jump_reg),
        .jump_addr   (jump_addr),
        .branch      (branch),
        .jr_target   (jr_target),
        .jump_index  (jump_index),
        .branch_imm  (branch_imm),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc_IF       (pc_IF),
        .instr_ID    (instr_ID),
        .pc_plus4_ID (pc_plus4_ID),
        .valid_ID    (valid_ID),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    // Address-tagged asynchronous instruction memory.
    assign imem_data = imem_addr + 32'h1000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic s, input logic f,
                          input logic jr, input logic ja, input logic br,
                          input logic [31:0] jt, input logic [25:0] ji,
                          input logic [15:0] bi,
                          input logic [31:0] epc, input logic [31:0] ein,
                          input logic [31:0] ep4, input logic ev,
                          input logic [31:0] esc, input logic [31:0] efc);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f;
        v.jr = jr; v.ja = ja; v.br = br;
        v.jr_target = jt; v.jidx = ji; v.bimm = bi;
        v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4; v.e_valid = ev;
        v.e_sc = esc; v.e_fc = efc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        stall      = v.stall;
        flush      = v.flush;
        jump_reg   = v.jr;
        jump_addr  = v.ja;
        branch     = v.br;
        jr_target  = v.jr_target;
        jump_index = v.jidx;
        branch_imm = v.bimm;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, " pc_IF"}, pc_IF, v.e_pc);
        checkOutput({tag, " imem_addr"}, imem_addr, v.e_pc);
        checkOutput({tag, " instr_ID"}, instr_ID, v.e_instr);
        checkOutput({tag, " pc_plus4_ID"}, pc_plus4_ID, v.e_pc4);
        checkOutput({tag, " valid_ID"}, {31'd0, valid_ID}, {31'd0, v.e_valid});
        checkOutput({tag, " stall_count"}, stall_count, v.e_sc);
        checkOutput({tag, " flush_count"}, flush_count, v.e_fc);
    endtask

    initial begin
        vec_t v;
        tests    = 0;
        failures = 0;

        //      rst s f jr ja br jr_target     jidx          bimm      pc            instr         pc+4          v  sc  fc
        addVec(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400000, 32'h0,        32'h0,        0, 0,  0); // 0 reset
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400004, 32'h10400000, 32'h00400004, 1, 0,  0); // 1
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400008, 32'h10400004, 32'h00400008, 1, 0,  0); // 2
        addVec(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400008, 32'h10400004, 32'h00400008, 1, 1,  0); // 3 stall
        addVec(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400008, 32'h10400004, 32'h00400008, 1, 2,  0); // 4 stall
        addVec(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400008, 32'h10400004, 32'h00400008, 1, 3,  0); // 5 stall
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h0040000C, 32'h10400008, 32'h0040000C, 1, 3,  0); // 6
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400010, 32'h1040000C, 32'h00400010, 1, 3,  0); // 7
        addVec(0, 0, 1, 0, 0, 1, 32'h0,        26'h0,        16'hFFFC, 32'h00400000, 32'h0,        32'h0,        0, 3,  1); // 8 branch back
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400004, 32'h10400000, 32'h00400004, 1, 3,  1); // 9
        addVec(0, 0, 1, 0, 1, 0, 32'h0,        26'h0100040,  16'h0,    32'h00400100, 32'h0,        32'h0,        0, 3,  2); // 10 j
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400104, 32'h10400100, 32'h00400104, 1, 3,  2); // 11
        addVec(0, 0, 1, 1, 1, 1, 32'h00400203, 26'h0000010,  16'h0100, 32'h00400200, 32'h0,        32'h0,        0, 3,  3); // 12 jr wins
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400204, 32'h10400200, 32'h00400204, 1, 3,  3); // 13
        addVec(0, 1, 1, 0, 0, 1, 32'h0,        26'h0,        16'h0004, 32'h00400204, 32'h10400200, 32'h00400204, 1, 4,  3); // 14 stall+flush
        addVec(0, 1, 1, 0, 0, 1, 32'h0,        26'h0,        16'h0004, 32'h00400204, 32'h10400200, 32'h00400204, 1, 5,  3); // 15 stall+flush
        addVec(0, 0, 1, 0, 0, 1, 32'h0,        26'h0,        16'h0004, 32'h00400214, 32'h0,        32'h0,        0, 5,  4); // 16 flush taken
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400218, 32'h10400214, 32'h00400218, 1, 5,  4); // 17
        addVec(0, 0, 1, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h0040021C, 32'h0,        32'h0,        0, 5,  5); // 18 flush, no select
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400220, 32'h1040021C, 32'h00400220, 1, 5,  5); // 19
        addVec(0, 0, 1, 0, 1, 1, 32'h0,        26'h0000010,  16'h0100, 32'h00000040, 32'h0,        32'h0,        0, 5,  6); // 20 j beats branch
        addVec(1, 0, 1, 0, 0, 1, 32'h0,        26'h0,        16'h0004, 32'h00400000, 32'h0,        32'h0,        0, 0,  0); // 21 reset in redirect
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00400004, 32'h10400000, 32'h00400004, 1, 0,  0); // 22
        addVec(0, 0, 1, 1, 0, 0, 32'hFFFFFFFF, 26'h0,        16'h0,    32'hFFFFFFFC, 32'h0,        32'h0,        0, 0,  1); // 23 jr to top
        addVec(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        16'h0,    32'h00000000, 32'h0FFFFFFC, 32'h00000000, 1, 0,  1); // 24 PC wraps

        applyStimulus(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkAll($sformatf("v%0d", i), vecs[i]);
        end

        // Mid-cycle input changes must not reach imem_addr.
        flush     = 1'b1;
        jump_reg  = 1'b1;
        jr_target = 32'h1234_5678;
        #2;
        checkOutput("imem_addr no comb path", imem_addr, 32'h00000000);

        // Reset during a stall discards the stall and clears the counters.
        stall = 1'b1;
        flush = 1'b0;
        jump_reg = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stall before reset sc", stall_count, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        v.e_pc = 32'h00400000; v.e_instr = 32'h0; v.e_pc4 = 32'h0;
        v.e_valid = 1'b0; v.e_sc = 32'd0; v.e_fc = 32'd0;
        checkAll("reset in stall", v);
        rst   = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        v.e_pc = 32'h00400004; v.e_instr = 32'h10400000; v.e_pc4 = 32'h00400004;
        v.e_valid = 1'b1;
        checkAll("after reset in stall", v);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
